// File: rtl/ram_8kx32_arbiter.sv
// Round-robin arbiter and access sequencer for two requesters sharing one RAM_8Kx32 macro.
// Commands are registered onto the RAM pins, and the address is held through the read-data cycle.
module ram_8kx32_arbiter #(
    parameter int AW = 13,
    parameter int DW = 32,
    parameter int NB = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          r0_req,
    input  logic [NB-1:0] r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic [NB-1:0] r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          ram_EN,
    output logic [NB-1:0] ram_WE,
    output logic [AW-1:0] ram_A,
    output logic [DW-1:0] ram_Di,
    input  logic [DW-1:0] ram_Do
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          owner;
    logic          last;
    logic          is_rd;
    logic [DW-1:0] rdata;
    logic [1:0]    rvalid;
    logic          gnt0;
    logic          gnt1;
    logic [NB-1:0] sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // On a tie, the requester that did not win last time gets the grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (r0_req && (!r1_req || last)) begin
                gnt0 = 1'b1;
            end else if (r1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we    = gnt1 ? r1_we    : r0_we;
        sel_addr  = gnt1 ? r1_addr  : r0_addr;
        sel_wdata = gnt1 ? r1_wdata : r0_wdata;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt0 || gnt1) state_next = ISSUE;
            ISSUE:   state_next = is_rd ? HOLD : IDLE;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ram_A is left untouched outside the grant edge so the bank mux stays correct in HOLD.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ram_EN <= 1'b0;
            ram_WE <= '0;
            ram_A  <= '0;
            ram_Di <= '0;
            owner  <= 1'b0;
            last   <= 1'b1;
            is_rd  <= 1'b0;
            rdata  <= '0;
            rvalid <= '0;
        end else begin
            rvalid <= '0;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        ram_A  <= sel_addr;
                        ram_Di <= sel_wdata;
                        ram_WE <= sel_we;
                        ram_EN <= 1'b1;
                        owner  <= gnt1;
                        last   <= gnt1;
                        is_rd  <= (sel_we == '0);
                    end
                end
                ISSUE: begin
                    ram_EN <= 1'b0;
                    ram_WE <= '0;
                end
                HOLD: begin
                    rdata         <= ram_Do;
                    rvalid[owner] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign r0_rvalid = rvalid[0];
    assign r1_rvalid = rvalid[1];
    assign r0_rdata  = rdata;
    assign r1_rdata  = rdata;

endmodule

// File: tb/tb_ram_8kx32_arbiter.sv
// Directed self-checking bench for ram_8kx32_arbiter with a banked RAM_8Kx32 behavioural model.
module tb_ram_8kx32_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [3:0]  r0_we = '0, r1_we = '0;
    logic [12:0] r0_addr = '0, r1_addr = '0;
    logic [31:0] r0_wdata = '0, r1_wdata = '0;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        ram_EN;
    logic [3:0]  ram_WE;
    logic [12:0] ram_A;
    logic [31:0] ram_Di, ram_Do;

    int checks = 0;
    int failures = 0;

    ram_8kx32_arbiter dut (
        .CLK(CLK), .RST(RST),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di), .ram_Do(ram_Do)
    );

    always #5 CLK = ~CLK;

    // Each 1K bank registers its own output; the live address picks the bank combinationally.
    logic [31:0] mem [0:8191];
    logic [31:0] bank_q [0:7];
    always @(posedge CLK) begin
        if (ram_EN) begin
            for (int b = 0; b < 4; b++)
                if (ram_WE[b]) mem[ram_A][8*b +: 8] <= ram_Di[8*b +: 8];
            bank_q[ram_A[12:10]] <= mem[ram_A];
        end
    end
    assign ram_Do = bank_q[ram_A[12:10]];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input int port, input logic req, input logic [3:0] we,
                         input logic [12:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    // Returns at the falling edge of the ISSUE cycle, with the request fields already scrambled.
    task automatic access(input int port, input logic [3:0] we, input logic [12:0] addr,
                          input logic [31:0] wdata, output logic granted);
        granted = 1'b0;
        drive(port, 1'b1, we, addr, wdata);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((port == 0 && r0_gnt) || (port == 1 && r1_gnt)) begin
                granted = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
        drive(port, 1'b0, 4'hF, ~addr, ~wdata);
    endtask

    task automatic write_txn(input int port, input logic [3:0] we, input logic [12:0] addr,
                             input logic [31:0] wdata, output logic granted);
        access(port, we, addr, wdata, granted);
        @(negedge CLK);
    endtask

    task automatic read_txn(input int port, input logic [12:0] addr, output logic granted,
                            output logic [12:0] a_issue, output logic [12:0] a_hold,
                            output logic v_own, output logic v_other, output logic [31:0] data);
        access(port, 4'h0, addr, 32'h0, granted);
        #1 a_issue = ram_A;
        @(negedge CLK);
        #1 a_hold = ram_A;
        @(negedge CLK);
        #1;
        v_own   = (port == 0) ? r0_rvalid : r1_rvalid;
        v_other = (port == 0) ? r1_rvalid : r0_rvalid;
        data    = (port == 0) ? r0_rdata  : r1_rdata;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        #1;
        checks++;
        if ({ram_EN, ram_WE} !== 5'b0) begin
            failures++; $display("[TB] FAIL reset_en_we: got %b required 0", {ram_EN, ram_WE});
        end
        checks++;
        if ({ram_A, ram_Di} !== 45'b0) begin
            failures++; $display("[TB] FAIL reset_addr_data: got %h/%h required 0", ram_A, ram_Di);
        end
        checks++;
        if ({r0_rvalid, r1_rvalid, r0_gnt, r1_gnt} !== 4'b0) begin
            failures++; $display("[TB] FAIL reset_strobes: got %b required 0000",
                                 {r0_rvalid, r1_rvalid, r0_gnt, r1_gnt});
        end
        checks++;
        if ({r0_rdata, r1_rdata} !== 64'b0) begin
            failures++; $display("[TB] FAIL reset_rdata: got %h/%h required 0", r0_rdata, r1_rdata);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_write_read();
        logic g; logic [12:0] ai, ah; logic vo, vt; logic [31:0] d;
        write_txn(0, 4'hF, 13'h0400, 32'hDEADBEEF, g);
        checks++;
        if (g !== 1'b1) begin failures++; $display("[TB] FAIL wr_grant: got %b required 1", g); end
        read_txn(0, 13'h0400, g, ai, ah, vo, vt, d);
        checks++;
        if (g !== 1'b1) begin failures++; $display("[TB] FAIL rd_grant: got %b required 1", g); end
        checks++;
        if (ai !== 13'h0400 || ah !== 13'h0400) begin
            failures++; $display("[TB] FAIL rd_addr_hold: got %h/%h required 0400/0400", ai, ah);
        end
        checks++;
        if ({vo, vt} !== 2'b10) begin
            failures++; $display("[TB] FAIL rd_rvalid: got r0=%b r1=%b required r0=1 r1=0", vo, vt);
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++; $display("[TB] FAIL rd_data: got %h required deadbeef", d);
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            failures++; $display("[TB] FAIL rvalid_pulse: got %b required 00", {r0_rvalid, r1_rvalid});
        end
    endtask

    task automatic test_alternate();
        logic g0, g1;
        logic e_g0, e_g1, e_v0, e_v1;
        write_txn(0, 4'hF, 13'h0001, 32'h11111111, g0);
        write_txn(1, 4'hF, 13'h1C01, 32'h22222222, g1);
        checks++;
        if ({g0, g1} !== 2'b11) begin
            failures++; $display("[TB] FAIL preload_grants: got %b required 11", {g0, g1});
        end
        drive(0, 1'b1, 4'h0, 13'h0001, 32'h0);
        drive(1, 1'b1, 4'h0, 13'h1C01, 32'h0);
        for (int cyc = 0; cyc <= 12; cyc++) begin
            #1;
            e_g0 = (cyc == 0 || cyc == 6);
            e_g1 = (cyc == 3 || cyc == 9);
            e_v0 = (cyc == 3 || cyc == 9);
            e_v1 = (cyc == 6 || cyc == 12);
            checks++;
            if ({r0_gnt, r1_gnt} !== {e_g0, e_g1}) begin
                failures++; $display("[TB] FAIL alt_gnt c%0d: got %b required %b",
                                     cyc, {r0_gnt, r1_gnt}, {e_g0, e_g1});
            end
            checks++;
            if ({r0_rvalid, r1_rvalid} !== {e_v0, e_v1}) begin
                failures++; $display("[TB] FAIL alt_rvalid c%0d: got %b required %b",
                                     cyc, {r0_rvalid, r1_rvalid}, {e_v0, e_v1});
            end
            if (e_v0) begin
                checks++;
                if (r0_rdata !== 32'h11111111) begin
                    failures++; $display("[TB] FAIL alt_r0_data c%0d: got %h required 11111111", cyc, r0_rdata);
                end
            end
            if (e_v1) begin
                checks++;
                if (r1_rdata !== 32'h22222222) begin
                    failures++; $display("[TB] FAIL alt_r1_data c%0d: got %h required 22222222", cyc, r1_rdata);
                end
            end
            @(negedge CLK);
            if (cyc == 9) begin
                drive(0, 1'b0, 4'h0, 13'h0, 32'h0);
                drive(1, 1'b0, 4'h0, 13'h0, 32'h0);
            end
        end
    endtask

    task automatic test_bank_hold();
        logic g; logic [12:0] ai, ah; logic vo, vt; logic [31:0] d;
        logic [12:0] addrs [2];
        logic [31:0] datas [2];
        addrs[0] = 13'h1FFF; datas[0] = 32'h5555FFFF;
        addrs[1] = 13'h03FF; datas[1] = 32'hAAAA0000;
        write_txn(0, 4'hF, 13'h03FF, 32'hAAAA0000, g);
        write_txn(0, 4'hF, 13'h1FFF, 32'h5555FFFF, g);
        for (int k = 0; k < 2; k++) begin
            read_txn(1, addrs[k], g, ai, ah, vo, vt, d);
            checks++;
            if (g !== 1'b1) begin failures++; $display("[TB] FAIL bank_grant%0d: got %b required 1", k, g); end
            checks++;
            if (ai !== addrs[k] || ah !== addrs[k]) begin
                failures++; $display("[TB] FAIL bank_addr_hold%0d: got %h/%h required %h", k, ai, ah, addrs[k]);
            end
            checks++;
            if ({vo, vt} !== 2'b10) begin
                failures++; $display("[TB] FAIL bank_rvalid%0d: got own=%b other=%b required 1/0", k, vo, vt);
            end
            checks++;
            if (d !== datas[k]) begin
                failures++; $display("[TB] FAIL bank_data%0d: got %h required %h", k, d, datas[k]);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic g; logic [12:0] ai, ah; logic vo, vt; logic [31:0] d;
        write_txn(1, 4'hF, 13'h0800, 32'h00000000, g);
        write_txn(0, 4'b0101, 13'h0800, 32'hFFFFFFFF, g);
        read_txn(0, 13'h0800, g, ai, ah, vo, vt, d);
        checks++;
        if (vo !== 1'b1 || d !== 32'h00FF00FF) begin
            failures++; $display("[TB] FAIL byte_lanes: got valid=%b data=%h required 1/00ff00ff", vo, d);
        end
    endtask

    task automatic test_reset_mid_read();
        logic g;
        access(0, 4'h0, 13'h0400, 32'h0, g);
        checks++;
        if (g !== 1'b1) begin failures++; $display("[TB] FAIL midrst_grant: got %b required 1", g); end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if ({ram_EN, ram_WE, ram_A, ram_Di} !== 50'b0) begin
            failures++; $display("[TB] FAIL midrst_ram_pins: got en=%b we=%h a=%h di=%h required 0",
                                 ram_EN, ram_WE, ram_A, ram_Di);
        end
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00 || r0_rdata !== 32'h0) begin
            failures++; $display("[TB] FAIL midrst_outputs: got rv=%b rdata=%h required 00/0",
                                 {r0_rvalid, r1_rvalid}, r0_rdata);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            checks++;
            if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
                failures++; $display("[TB] FAIL midrst_no_rvalid c%0d: got %b required 00",
                                     cyc, {r0_rvalid, r1_rvalid});
            end
            @(negedge CLK);
        end
        drive(0, 1'b1, 4'h0, 13'h0001, 32'h0);
        drive(1, 1'b1, 4'h0, 13'h1C01, 32'h0);
        #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            failures++; $display("[TB] FAIL midrst_tie: got %b required 10", {r0_gnt, r1_gnt});
        end
        @(negedge CLK);
        drive(0, 1'b0, 4'h0, 13'h0, 32'h0);
        drive(1, 1'b0, 4'h0, 13'h0, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h11111111) begin
            failures++; $display("[TB] FAIL midrst_after: got valid=%b data=%h required 1/11111111",
                                 r0_rvalid, r0_rdata);
        end
        @(negedge CLK);
    endtask

    task automatic test_mixed();
        logic e_g0, e_g1, e_v1;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        drive(0, 1'b1, 4'hF, 13'h0002, 32'h33333333);
        drive(1, 1'b1, 4'h0, 13'h1C01, 32'h0);
        for (int cyc = 0; cyc <= 6; cyc++) begin
            #1;
            e_g0 = (cyc == 0);
            e_g1 = (cyc == 2);
            e_v1 = (cyc == 5);
            checks++;
            if ({r0_gnt, r1_gnt} !== {e_g0, e_g1}) begin
                failures++; $display("[TB] FAIL mixed_gnt c%0d: got %b required %b",
                                     cyc, {r0_gnt, r1_gnt}, {e_g0, e_g1});
            end
            checks++;
            if ({r0_rvalid, r1_rvalid} !== {1'b0, e_v1}) begin
                failures++; $display("[TB] FAIL mixed_rvalid c%0d: got %b required %b",
                                     cyc, {r0_rvalid, r1_rvalid}, {1'b0, e_v1});
            end
            if (e_v1) begin
                checks++;
                if (r1_rdata !== 32'h22222222) begin
                    failures++; $display("[TB] FAIL mixed_data: got %h required 22222222", r1_rdata);
                end
            end
            @(negedge CLK);
            if (cyc == 0) drive(0, 1'b0, 4'h0, 13'h0, 32'h0);
            if (cyc == 2) drive(1, 1'b0, 4'h0, 13'h0, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_bank_hold();
        test_byte_lanes();
        test_reset_mid_read();
        test_mixed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
